// File: rtl/wb_slave_bridge.sv
// Wishbone classic slave: NUM_REGS control registers followed by an SRAM window.
// Optional macro WB_SLAVE_TIMEOUT_EN bounds the wait for mem_opdone to TIMEOUT cycles.
module wb_slave_bridge #(
   parameter logic [31:0] ADDR_OFFSET = 32'h3000_0000,
   parameter int          NUM_REGS    = 4,
   parameter int          MEM_AW      = 8,
   parameter int          TIMEOUT     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   input  logic                     wb_we_i,
   input  logic [3:0]               wb_sel_i,
   input  logic [31:0]              wb_adr_i,
   input  logic [31:0]              wb_dat_i,
   output logic                     wb_ack_o,
   output logic                     wb_err_o,
   output logic [31:0]              wb_dat_o,
   output logic [1:0]               mem_op,
   output logic [MEM_AW-1:0]        mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_sel,
   input  logic [31:0]              mem_rdata,
   input  logic                     mem_opdone,
   input  logic                     finished,
   output logic [NUM_REGS*32-1:0]   regs_o
);

   localparam int          RIW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] LP_WIN_WORDS = 32'(NUM_REGS) + (32'd1 << MEM_AW);
   localparam logic [1:0]  OP_NONE      = 2'b00;
   localparam logic [1:0]  OP_RD        = 2'b01;
   localparam logic [1:0]  OP_WR        = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DECODE   = 3'd1,
      S_MEM_WAIT = 3'd2,
      S_ACK      = 3'd3,
      S_ERR      = 3'd4
   } state_t;

   if ((NUM_REGS < 2) || (NUM_REGS > 8) || (TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_param_range
      $error("wb_slave_bridge: NUM_REGS or TIMEOUT out of range");
   end

   state_t         r_state;
   state_t         w_next;
   logic [31:0]    r_adr;
   logic [31:0]    r_dat;
   logic [3:0]     r_sel;
   logic           r_we;
   logic [31:0]    r_regs [NUM_REGS];

   logic [31:0]    w_off;
   logic [31:0]    w_idx;
   logic           w_bad;
   logic           w_is_reg;
   logic [RIW-1:0] w_reg_sel;
   logic [31:0]    w_lane_mask;
   logic           w_start;
   logic           w_reg_wr;
   logic           w_reg_rd;
   logic           w_mem_start;
   logic           w_mem_done;
   logic           w_mem_abort;

`ifdef WB_SLAVE_TIMEOUT_EN
   localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]     r_tmo;

   // Cycles spent in MEM_WAIT; restarted whenever a memory operation is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tmo <= 8'd0;
      end else if (w_mem_start) begin
         r_tmo <= 8'd0;
      end else if (r_state == S_MEM_WAIT) begin
         r_tmo <= r_tmo + 8'd1;
      end else begin
         r_tmo <= r_tmo;
      end
   end
`endif

   // Window offset is modulo 2^32, so addresses below ADDR_OFFSET wrap high and fail.
   assign w_off       = r_adr - ADDR_OFFSET;
   assign w_idx       = {2'b00, w_off[31:2]};
   assign w_bad       = (w_off[1:0] != 2'b00) || (w_idx >= LP_WIN_WORDS);
   assign w_is_reg    = (w_idx < 32'(NUM_REGS));
   assign w_reg_sel   = w_idx[RIW-1:0];
   assign w_lane_mask = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
      assign regs_o[32*k +: 32] = r_regs[k];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_next = S_DECODE;
            else         w_next = S_IDLE;
         end
         S_DECODE: begin
            if (w_bad)         w_next = S_ERR;
            else if (w_is_reg) w_next = S_ACK;
            else               w_next = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            if (mem_opdone)       w_next = S_ACK;
            else if (w_mem_abort) w_next = S_ERR;
            else                  w_next = S_MEM_WAIT;
         end
         S_ACK:   w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Per-state action strobes consumed by the datapath registers.
   always_comb begin
      w_start     = 1'b0;
      w_reg_wr    = 1'b0;
      w_reg_rd    = 1'b0;
      w_mem_start = 1'b0;
      w_mem_done  = 1'b0;
      w_mem_abort = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_start = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
         end
         S_DECODE: begin
            if (!w_bad && w_is_reg) begin
               w_reg_wr = r_we;
               w_reg_rd = ~r_we;
            end else begin
               w_mem_start = ~w_bad;
            end
         end
         S_MEM_WAIT: begin
            w_mem_done = mem_opdone;
`ifdef WB_SLAVE_TIMEOUT_EN
            w_mem_abort = ~mem_opdone & (r_tmo == LP_TMO_LAST);
`endif
         end
         default: begin
            w_start = 1'b0;
         end
      endcase
   end

   // Request latch, bus responses, SRAM command and control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_adr     <= 32'h0;
         r_dat     <= 32'h0;
         r_sel     <= 4'h0;
         r_we      <= 1'b0;
         wb_ack_o  <= 1'b0;
         wb_err_o  <= 1'b0;
         wb_dat_o  <= 32'h0;
         mem_op    <= OP_NONE;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
         mem_sel   <= 4'h0;
         for (int k = 0; k < NUM_REGS; k++) begin
            r_regs[k] <= 32'h0;
         end
      end else begin
         wb_ack_o <= (r_state == S_ACK);
         wb_err_o <= (r_state == S_ERR);

         if (w_start) begin
            r_adr <= wb_adr_i;
            r_dat <= wb_dat_i;
            r_sel <= wb_sel_i;
            r_we  <= wb_we_i;
         end

         if (r_state == S_DECODE) begin
            wb_dat_o <= w_reg_rd ? r_regs[w_reg_sel] : 32'h0;
         end else if (w_mem_done && !r_we) begin
            wb_dat_o <= mem_rdata;
         end

         if (w_mem_start) begin
            mem_op    <= r_we ? OP_WR : OP_RD;
            mem_addr  <= MEM_AW'(w_idx - 32'(NUM_REGS));
            mem_wdata <= r_dat;
            mem_sel   <= r_sel;
         end else if (w_mem_done || w_mem_abort) begin
            mem_op <= OP_NONE;
         end

         // A bus write to the status register takes priority over the finished clear.
         for (int k = 0; k < NUM_REGS; k++) begin
            if (w_reg_wr && (w_idx == 32'(k))) begin
               r_regs[k] <= (r_regs[k] & ~w_lane_mask) | (r_dat & w_lane_mask);
            end else if ((k == 1) && finished) begin
               r_regs[k] <= 32'h0;
            end
         end
      end
   end

endmodule

// File: doc/wb_slave_bridge.md
WB_SLAVE_BRIDGE -- requirements
Module: wb_slave_bridge

Interface
REQ-001 SHALL have parameter ADDR_OFFSET, default 32'h3000_0000, base byte address of the slave window.
REQ-002 SHALL have parameter NUM_REGS, default 4, range 2..8, count of 32-bit control registers at the bottom of the window.
REQ-003 SHALL have parameter MEM_AW, default 8, SRAM word-address width.
REQ-004 SHALL have parameter TIMEOUT, default 16, range 2..255, max cycles waiting for mem_opdone.
REQ-005 SHALL have port clk, input, 1, clock; reset synchronous, active-high; clock clk.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i, inputs, 1 each, Wishbone classic handshake.
REQ-008 SHALL have ports wb_sel_i (input, 4), wb_adr_i (input, 32), wb_dat_i (input, 32), Wishbone byte lanes, address and write data.
REQ-009 SHALL have ports wb_ack_o and wb_err_o (output, 1 each), and wb_dat_o (output, 32), read data.
REQ-010 SHALL have ports mem_op (output, 2; 00 none, 01 read, 11 write), mem_addr (output, MEM_AW), mem_wdata (output, 32), mem_sel (output, 4).
REQ-011 SHALL have ports mem_rdata (input, 32) and mem_opdone (input, 1), SRAM read data and completion.
REQ-012 SHALL have ports finished (input, 1), status-clear pulse, and regs_o (output, NUM_REGS*32), reg k at bits [32k+31:32k].

Function
REQ-013 SHALL implement states IDLE, DECODE, MEM_WAIT, ACK, ERR.
REQ-014 In IDLE, with wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o, SHALL latch adr/dat/sel/we and go to DECODE.
REQ-015 DECODE: off = adr - ADDR_OFFSET (32-bit modulo); off[1:0]!=0 or off/4 >= NUM_REGS + 2^MEM_AW -> ERR.
REQ-016 DECODE, off/4 < NUM_REGS: write updates reg off/4 only in lanes where sel=1; read loads wb_dat_o; go to ACK.
REQ-017 DECODE, memory hit: mem_addr = off/4 - NUM_REGS, mem_sel = sel, mem_wdata = dat, mem_op = 11 (write) or 01 (read); go to MEM_WAIT.
REQ-018 MEM_WAIT: on mem_opdone, mem_op <= 00, read captures mem_rdata into wb_dat_o, go to ACK.
REQ-019 ACK and ERR SHALL assert wb_ack_o resp. wb_err_o for exactly one cycle, then return to IDLE; never both.
REQ-020 Register access latency: ack high on 3rd edge after request is first sampled (edges: IDLE->DECODE, DECODE->ACK, ACK output).
REQ-021 Failing accesses SHALL write no register, issue no mem_op, and return wb_dat_o = 0.
REQ-022 finished=1 SHALL clear reg 1 (status) that edge without stalling the FSM; a simultaneous bus write to reg 1 wins.
REQ-023 wb_dat_o SHALL hold its value until the next access's DECODE; mem_addr/mem_wdata/mem_sel hold after completion.

Reset
REQ-024 On reset: state IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, mem_op=00, mem_addr=0, mem_wdata=0, mem_sel=0, all regs 0.
REQ-025 Reset mid-access SHALL drop mem_op to 00 on that edge and produce no ack or err for the aborted access.

Configuration
REQ-026 Macro WB_SLAVE_TIMEOUT_EN defined: MEM_WAIT counts cycles; reaching TIMEOUT without mem_opdone sets mem_op=00 and goes to ERR; counter resets on entry to MEM_WAIT.
REQ-027 Macro WB_SLAVE_TIMEOUT_EN undefined: MEM_WAIT waits indefinitely; no counter logic present; TIMEOUT ignored.

Verification
REQ-028 Write 0x3000_0000 dat 0xDEAD_BEEF sel 0101 -> reg0 = 0x00AD_00EF, ack one cycle on 3rd edge.
REQ-029 Read 0x3000_0010 (NUM_REGS=4), mem_opdone 3 cycles later with mem_rdata 0x1234_5678 -> mem_op=01, mem_addr=0, wb_dat_o=0x1234_5678, ack.
REQ-030 Access 0x3000_0002 or 0x3000_0410 (MEM_AW=8) -> wb_err_o one cycle, no mem_op, no register change.
REQ-031 Write reg1=0x5 then finished pulse -> reg1=0; finished coinciding with write of 0x7 to reg1 -> reg1=0x7.
REQ-032 WB_SLAVE_TIMEOUT_EN, TIMEOUT=16, memory read with no mem_opdone -> mem_op back to 00 and wb_err_o after 16 cycles; reset asserted in MEM_WAIT -> mem_op=00 next edge, no ack.
